// File: rtl/sprite_bounce_engine.sv
// ============================================================================
// Module   : sprite_bounce_engine
// Brief    : Frame-stepped bouncing-sprite motion engine with edge clamping,
//            sprite-local raster coordinates and bounce event pulses.
//            Optional macro BOUNCE_CNT_EN builds a saturating bounce counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_bounce_engine #(
    parameter int COORD_W  = 10,
    parameter int SPRITE_W = 128,
    parameter int SPRITE_H = 128,
    parameter int DISP_W   = 640,
    parameter int DISP_H   = 480,
    parameter int START_X  = 200,
    parameter int START_Y  = 200,
    parameter int COLOR_W  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic [2:0]         speed,
    input  logic               pause,
    input  logic               tile_mode,
    output logic [COORD_W-1:0] sprite_left,
    output logic [COORD_W-1:0] sprite_top,
    output logic [COORD_W-1:0] local_x,
    output logic [COORD_W-1:0] local_y,
    output logic               in_sprite,
    output logic [COLOR_W-1:0] color_index,
    output logic               bounce_x,
    output logic               bounce_y,
    output logic               corner,
    output logic [15:0]        bounce_count
);

    // One extra bit keeps left+speed from wrapping before the clamp compare.
    localparam int               PW        = COORD_W + 1;
    localparam logic [PW-1:0]    C_MAX_X   = PW'(DISP_W - SPRITE_W);
    localparam logic [PW-1:0]    C_MAX_Y   = PW'(DISP_H - SPRITE_H);
    localparam logic [PW-1:0]    C_SPR_W   = PW'(SPRITE_W);
    localparam logic [PW-1:0]    C_SPR_H   = PW'(SPRITE_H);
    localparam logic [COORD_W-1:0] C_START_X = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] C_START_Y = COORD_W'(START_Y);

    logic [COORD_W-1:0] left_q,  left_d;
    logic [COORD_W-1:0] top_q,   top_d;
    logic               dir_x_q, dir_x_d;
    logic               dir_y_q, dir_y_d;
    logic [COORD_W-1:0] prev_y_q, prev_y_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               bounce_x_q, bounce_x_d;
    logic               bounce_y_q, bounce_y_d;
    logic               corner_q,   corner_d;

    logic               frame_edge_w;
    logic               update_w;
    logic [PW-1:0]      spd_w;
    logic [PW-1:0]      nx_w, ny_w;
    logic               ndx_w, ndy_w;
    logic               bx_w, by_w;

    // Shared per-axis step: clamp on overshoot and reverse direction.
    function automatic void axis_step(
        input  logic [PW-1:0] pos,
        input  logic          dir,
        input  logic [PW-1:0] spd,
        input  logic [PW-1:0] maxv,
        output logic [PW-1:0] npos,
        output logic          ndir,
        output logic          bnc
    );
        npos = pos;
        ndir = dir;
        bnc  = 1'b0;
        if (dir) begin
            if ((pos + spd) >= maxv) begin
                npos = maxv;
                ndir = 1'b0;
                bnc  = 1'b1;
            end else begin
                npos = pos + spd;
            end
        end else begin
            if (pos <= spd) begin
                npos = '0;
                ndir = 1'b1;
                bnc  = 1'b1;
            end else begin
                npos = pos - spd;
            end
        end
    endfunction

    always_comb begin
        spd_w        = {{(PW-3){1'b0}}, speed};
        frame_edge_w = (pix_y == '0) && (prev_y_q != '0);
        update_w     = frame_edge_w && !pause && (speed != 3'd0);

        axis_step({1'b0, left_q}, dir_x_q, spd_w, C_MAX_X, nx_w, ndx_w, bx_w);
        axis_step({1'b0, top_q},  dir_y_q, spd_w, C_MAX_Y, ny_w, ndy_w, by_w);

        prev_y_d   = pix_y;
        left_d     = left_q;
        top_d      = top_q;
        dir_x_d    = dir_x_q;
        dir_y_d    = dir_y_q;
        color_d    = color_q;
        bounce_x_d = 1'b0;
        bounce_y_d = 1'b0;
        corner_d   = 1'b0;

        if (update_w) begin
            left_d     = nx_w[COORD_W-1:0];
            top_d      = ny_w[COORD_W-1:0];
            dir_x_d    = ndx_w;
            dir_y_d    = ndy_w;
            color_d    = color_q + COLOR_W'({1'b0, bx_w} + {1'b0, by_w});
            bounce_x_d = bx_w;
            bounce_y_d = by_w;
            corner_d   = bx_w & by_w;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            left_q     <= C_START_X;
            top_q      <= C_START_Y;
            dir_x_q    <= 1'b1;
            dir_y_q    <= 1'b0;
            prev_y_q   <= '0;
            color_q    <= '0;
            bounce_x_q <= 1'b0;
            bounce_y_q <= 1'b0;
            corner_q   <= 1'b0;
        end else begin
            left_q     <= left_d;
            top_q      <= top_d;
            dir_x_q    <= dir_x_d;
            dir_y_q    <= dir_y_d;
            prev_y_q   <= prev_y_d;
            color_q    <= color_d;
            bounce_x_q <= bounce_x_d;
            bounce_y_q <= bounce_y_d;
            corner_q   <= corner_d;
        end
    end

`ifdef BOUNCE_CNT_EN
    logic [15:0] bcnt_q, bcnt_d;

    always_comb begin
        bcnt_d = bcnt_q;
        if (update_w && (bx_w || by_w) && (bcnt_q != 16'hFFFF)) begin
            bcnt_d = bcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcnt_q <= 16'h0000;
        end else begin
            bcnt_q <= bcnt_d;
        end
    end

    assign bounce_count = bcnt_q;
`else
    assign bounce_count = 16'h0000;
`endif

    // Raster left of / above the sprite wraps to a large value, so it reads as outside.
    assign local_x     = pix_x - left_q;
    assign local_y     = pix_y - top_q;
    assign in_sprite   = tile_mode ||
                         (({1'b0, local_x} < C_SPR_W) && ({1'b0, local_y} < C_SPR_H));

    assign sprite_left = left_q;
    assign sprite_top  = top_q;
    assign color_index = color_q;
    assign bounce_x    = bounce_x_q;
    assign bounce_y    = bounce_y_q;
    assign corner      = corner_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_bounce_engine.sv
// ============================================================================
// Module   : tb_sprite_bounce_engine
// Brief    : Self-checking bench for sprite_bounce_engine (scoreboard + table).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_bounce_engine;

    localparam int C_MAX_X = 640 - 128;
    localparam int C_MAX_Y = 480 - 128;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] pix_x, pix_y, pix_y2;
    logic [2:0] speed, speed2;
    logic       pause, tile_mode;

    logic [9:0]  sprite_left, sprite_top, local_x, local_y;
    logic        in_sprite, bounce_x, bounce_y, corner;
    logic [2:0]  color_index;
    logic [15:0] bounce_count;

    logic [9:0]  left2, top2, lx2, ly2;
    logic        ins2, bx2, by2, cr2;
    logic [2:0]  col2;
    logic [15:0] cnt2;

    always #5 clk = ~clk;

    sprite_bounce_engine dut (
        .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
        .speed(speed), .pause(pause), .tile_mode(tile_mode),
        .sprite_left(sprite_left), .sprite_top(sprite_top),
        .local_x(local_x), .local_y(local_y), .in_sprite(in_sprite),
        .color_index(color_index), .bounce_x(bounce_x), .bounce_y(bounce_y),
        .corner(corner), .bounce_count(bounce_count)
    );

    sprite_bounce_engine #(.START_X(505), .START_Y(7)) dut2 (
        .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y2),
        .speed(speed2), .pause(1'b0), .tile_mode(1'b0),
        .sprite_left(left2), .sprite_top(top2),
        .local_x(lx2), .local_y(ly2), .in_sprite(ins2),
        .color_index(col2), .bounce_x(bx2), .bounce_y(by2),
        .corner(cr2), .bounce_count(cnt2)
    );

    typedef struct {
        int left; int top; int col; int cnt;
        bit bx; bit by; bit cr;
    } exp_t;

    typedef struct {
        int px; int py; bit tile;
        int lx; int ly; bit ins;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[7];

    int total = 0;
    int bad   = 0;

    int mx, my, mcol, mcnt;
    bit mdx, mdy;
    bit last_bx, last_by, last_cr;

`ifdef BOUNCE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mx = 200; my = 200; mdx = 1'b1; mdy = 1'b0; mcol = 0; mcnt = 0;
    endtask

    // Reference behaviour of one frame edge, written from the axis rules.
    task automatic model_step(output exp_t e);
        bit bx, by;
        bx = 1'b0; by = 1'b0;
        if (!pause && speed != 0) begin
            if (mdx) begin
                if (mx + int'(speed) >= C_MAX_X) begin mx = C_MAX_X; mdx = 1'b0; bx = 1'b1; end
                else mx = mx + int'(speed);
            end else begin
                if (mx <= int'(speed)) begin mx = 0; mdx = 1'b1; bx = 1'b1; end
                else mx = mx - int'(speed);
            end
            if (mdy) begin
                if (my + int'(speed) >= C_MAX_Y) begin my = C_MAX_Y; mdy = 1'b0; by = 1'b1; end
                else my = my + int'(speed);
            end else begin
                if (my <= int'(speed)) begin my = 0; mdy = 1'b1; by = 1'b1; end
                else my = my - int'(speed);
            end
            mcol = (mcol + int'(bx) + int'(by)) % 8;
            if ((bx || by) && mcnt < 65535) mcnt++;
        end
        e.left = mx; e.top = my; e.col = mcol;
        e.cnt  = CNT_EN ? mcnt : 0;
        e.bx = bx; e.by = by; e.cr = bx & by;
    endtask

    task automatic check_state(input string tag);
        chk({tag, " left"},  int'(sprite_left),  mx);
        chk({tag, " top"},   int'(sprite_top),   my);
        chk({tag, " color"}, int'(color_index),  mcol);
        chk({tag, " count"}, int'(bounce_count), CNT_EN ? mcnt : 0);
        chk({tag, " pulses"}, int'({bounce_x, bounce_y, corner}), 0);
    endtask

    task automatic do_edge();
        exp_t e, g;
        @(negedge clk) pix_y = 10'd524;
        @(negedge clk) pix_y = 10'd0;
        model_step(e);
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            chk("scoreboard underflow", 1, 0);
        end else begin
            g = sb.pop_front();
            chk("edge left",   int'(sprite_left),  g.left);
            chk("edge top",    int'(sprite_top),   g.top);
            chk("edge color",  int'(color_index),  g.col);
            chk("edge count",  int'(bounce_count), g.cnt);
            chk("edge bx",     int'(bounce_x),     int'(g.bx));
            chk("edge by",     int'(bounce_y),     int'(g.by));
            chk("edge corner", int'(corner),       int'(g.cr));
        end
        last_bx = bounce_x; last_by = bounce_y; last_cr = corner;
        pix_y = 10'd1;
        @(negedge clk);
        chk("pulse one cycle", int'({bounce_x, bounce_y, corner}), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{px: 200, py: 200, tile: 1'b0, lx: 0,    ly: 0,    ins: 1'b1};
        vecs[1] = '{px: 199, py: 250, tile: 1'b0, lx: 1023, ly: 50,   ins: 1'b0};
        vecs[2] = '{px: 327, py: 327, tile: 1'b0, lx: 127,  ly: 127,  ins: 1'b1};
        vecs[3] = '{px: 328, py: 200, tile: 1'b0, lx: 128,  ly: 0,    ins: 1'b0};
        vecs[4] = '{px: 200, py: 199, tile: 1'b0, lx: 0,    ly: 1023, ins: 1'b0};
        vecs[5] = '{px: 199, py: 250, tile: 1'b1, lx: 1023, ly: 50,   ins: 1'b1};
        vecs[6] = '{px: 0,   py: 0,   tile: 1'b0, lx: 824,  ly: 824,  ins: 1'b0};

        rst_n = 1'b0; pix_x = '0; pix_y = 10'd1; pix_y2 = 10'd1;
        speed = 3'd1; speed2 = 3'd7; pause = 1'b0; tile_mode = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check_state("reset");

        // Raster-to-local mapping; pause keeps any pix_y=0 from moving the sprite.
        pause = 1'b1;
        foreach (vecs[i]) begin
            @(negedge clk);
            pix_x = 10'(vecs[i].px); pix_y = 10'(vecs[i].py); tile_mode = vecs[i].tile;
            #1;
            chk($sformatf("vec%0d local_x", i),   int'(local_x),   vecs[i].lx);
            chk($sformatf("vec%0d local_y", i),   int'(local_y),   vecs[i].ly);
            chk($sformatf("vec%0d in_sprite", i), int'(in_sprite), int'(vecs[i].ins));
        end
        @(negedge clk);
        pix_x = '0; pix_y = 10'd1; tile_mode = 1'b0; pause = 1'b0;
        @(negedge clk);
        check_state("after table");

        speed = 3'd1;
        repeat (3) do_edge();
        chk("speed1 left", int'(sprite_left), 203);
        chk("speed1 top",  int'(sprite_top),  197);
        chk("speed1 color", int'(color_index), 0);

        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        speed = 3'd7;
        for (int f = 1; f <= 45; f++) begin
            do_edge();
            if (f == 29) begin
                chk("f29 top", int'(sprite_top), 0);
                chk("f29 bounce_y", int'(last_by), 1);
                chk("f29 bounce_x", int'(last_bx), 0);
                chk("f29 color", int'(color_index), 1);
            end
            if (f == 45) begin
                chk("f45 left", int'(sprite_left), 512);
                chk("f45 bounce_x", int'(last_bx), 1);
                chk("f45 color", int'(color_index), 2);
                chk("f45 count", int'(bounce_count), CNT_EN ? 2 : 0);
            end
        end

        pause = 1'b1;
        repeat (5) do_edge();
        chk("pause left", int'(sprite_left), 512);
        chk("pause top",  int'(sprite_top),  112);
        chk("pause color", int'(color_index), 2);
        pause = 1'b0; speed = 3'd0;
        repeat (2) do_edge();
        speed = 3'd3;
        do_edge();
        chk("release left", int'(sprite_left), 509);
        chk("release top",  int'(sprite_top),  115);

        @(negedge clk) pix_y = 10'd100;
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        check_state("midframe reset");

        // Reset coinciding with a frame edge must win over the update.
        speed = 3'd5;
        do_edge();
        @(negedge clk) pix_y = 10'd524;
        @(negedge clk) pix_y = 10'd0; rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1; pix_y = 10'd1;
        model_reset();
        check_state("reset on edge");

        @(negedge clk) pix_y2 = 10'd524;
        @(negedge clk) pix_y2 = 10'd0;
        @(negedge clk);
        chk("corner left",  int'(left2), 512);
        chk("corner top",   int'(top2),  0);
        chk("corner bx",    int'(bx2),   1);
        chk("corner by",    int'(by2),   1);
        chk("corner pulse", int'(cr2),   1);
        chk("corner color", int'(col2),  2);
        chk("corner count", int'(cnt2),  CNT_EN ? 1 : 0);
        pix_y2 = 10'd1;
        @(negedge clk);
        chk("corner pulses clear", int'({bx2, by2, cr2}), 0);

        chk("scoreboard empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
